// File: rtl/dma_wr_pkg.sv
// -----------------------------------------------------------------------------
// dma_wr_pkg
// Shared types and constants for the AXI4 write-burst DMA master.
//   dma_wr_state_t  : FSM state encoding (IDLE, ADDR, DATA, RESP)
//   AXI_BURST_INCR  : AWBURST code for incrementing bursts
//   AXI_RESP_OKAY   : BRESP code for a successful write
//   AXI_RESP_SLVERR : BRESP code for a slave error
//   axi_size_f()    : AWSIZE encoding for a given data-bus width in bits
// -----------------------------------------------------------------------------
package dma_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } dma_wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Bytes per beat expressed as log2, as carried on AWSIZE.
    function automatic logic [2:0] axi_size_f(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dma_wr_master.sv
// -----------------------------------------------------------------------------
// dma_wr_master
// AXI4 write-burst master. Accepts a (base address, beat count) command,
// drains a valid/ready source stream and issues it as INCR bursts of at most
// MAX_BURST_g beats, one burst outstanding at a time (AW, then W, then B).
// done_o pulses for one cycle once the transfer has finished.
//
// Optional feature macro: DMA_WR_BRESP_CHK_EN
//   defined   : non-OKAY BRESP sets sticky err_o and abandons remaining bursts
//   undefined : BRESP ignored, err_o tied low
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_addr_i, cmd_len_i    byte base address (beat aligned), beat count
//   busy_o, done_o, err_o    status: in progress, end pulse, sticky error
//   src_valid_i/src_ready_o  source stream handshake, src_data_i payload
//   m_axi_aw*                write address channel
//   m_axi_w*                 write data channel
//   m_axi_b*                 write response channel
// -----------------------------------------------------------------------------
module dma_wr_master
    import dma_wr_pkg::*;
#(
    parameter int unsigned AXI_DW_g    = 64,
    parameter int unsigned AXI_AW_g    = 32,
    parameter int unsigned MAX_BURST_g = 16,
    parameter int unsigned LEN_W_g     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [AXI_AW_g-1:0]   cmd_addr_i,
    input  logic [LEN_W_g-1:0]    cmd_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    input  logic [AXI_DW_g-1:0]   src_data_i,
    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,
    output logic [AXI_AW_g-1:0]   m_axi_awaddr_o,
    output logic [7:0]            m_axi_awlen_o,
    output logic [2:0]            m_axi_awsize_o,
    output logic [1:0]            m_axi_awburst_o,
    output logic [2:0]            m_axi_awprot_o,
    output logic [3:0]            m_axi_awcache_o,
    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,
    output logic [AXI_DW_g-1:0]   m_axi_wdata_o,
    output logic [AXI_DW_g/8-1:0] m_axi_wstrb_o,
    output logic                  m_axi_wlast_o,
    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o,
    input  logic [1:0]            m_axi_bresp_i
);

    localparam logic [2:0] AWSIZE = axi_size_f(AXI_DW_g);

    dma_wr_state_t         state_q, state_d;
    logic [AXI_AW_g-1:0]   cur_addr_q;
    logic [LEN_W_g-1:0]    remaining_q;
    logic [8:0]            burst_beats_q;
    logic [8:0]            beat_cnt_q;
    logic [7:0]            awlen_q;
    logic                  done_q;

    logic                  cmd_hs, aw_hs, w_hs, b_hs;
    logic                  last_beat, b_bad, b_final, load_burst;
    logic [LEN_W_g-1:0]    rem_after, burst_src;
    logic [AXI_AW_g-1:0]   addr_after;
    logic [8:0]            burst_calc;

    // ---------------------------------------------------------------- handshakes
    assign cmd_ready_o = (state_q == ST_IDLE) && rst_n_i;
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;
    assign aw_hs       = (state_q == ST_ADDR) && m_axi_awready_i;
    assign w_hs        = (state_q == ST_DATA) && src_valid_i && m_axi_wready_i;
    assign b_hs        = (state_q == ST_RESP) && m_axi_bvalid_i;
    assign last_beat   = (beat_cnt_q == burst_beats_q - 9'd1);

    assign rem_after   = remaining_q - LEN_W_g'(burst_beats_q);
    assign addr_after  = cur_addr_q + (AXI_AW_g'(burst_beats_q) << AWSIZE);

`ifdef DMA_WR_BRESP_CHK_EN
    assign b_bad = b_hs && (m_axi_bresp_i != AXI_RESP_OKAY);
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp_i;
    assign b_bad        = 1'b0;
`endif

    assign b_final    = (rem_after == '0) || b_bad;

    // Next burst size comes from the command on accept, or from what is left
    // after the burst that just got its response.
    assign burst_src  = cmd_hs ? cmd_len_i : rem_after;
    assign load_burst = (cmd_hs && (cmd_len_i != '0)) || (b_hs && !b_final);

    always_comb begin
        burst_calc = 9'(burst_src);
        if (32'(burst_src) > MAX_BURST_g) begin
            burst_calc = 9'(MAX_BURST_g);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_hs && (cmd_len_i != '0)) state_d = ST_ADDR;
            ST_ADDR: if (aw_hs) state_d = ST_DATA;
            ST_DATA: if (w_hs && last_beat) state_d = ST_RESP;
            ST_RESP: if (b_hs) state_d = b_final ? ST_IDLE : ST_ADDR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            awlen_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            if (cmd_hs) begin
                cur_addr_q  <= cmd_addr_i;
                remaining_q <= cmd_len_i;
            end else if (b_hs) begin
                cur_addr_q  <= addr_after;
                remaining_q <= rem_after;
            end

            if (load_burst) begin
                burst_beats_q <= burst_calc;
                awlen_q       <= 8'(burst_calc - 9'd1);
            end

            if (aw_hs) begin
                beat_cnt_q <= '0;
            end else if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 9'd1;
            end

            done_q <= (cmd_hs && (cmd_len_i == '0)) || (b_hs && b_final);
        end
    end

`ifdef DMA_WR_BRESP_CHK_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (cmd_hs) begin
            err_q <= 1'b0;
        end else if (b_bad) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // ---------------------------------------------------------------- outputs
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;

    assign m_axi_awvalid_o = (state_q == ST_ADDR);
    assign m_axi_awaddr_o  = cur_addr_q;
    assign m_axi_awlen_o   = awlen_q;
    assign m_axi_awsize_o  = AWSIZE;
    assign m_axi_awburst_o = AXI_BURST_INCR;
    assign m_axi_awprot_o  = '0;
    assign m_axi_awcache_o = '0;

    // W is a straight pass-through of the source, only while in DATA.
    assign m_axi_wvalid_o  = (state_q == ST_DATA) && src_valid_i;
    assign src_ready_o     = (state_q == ST_DATA) && m_axi_wready_i;
    assign m_axi_wdata_o   = (state_q == ST_DATA) ? src_data_i : '0;
    assign m_axi_wstrb_o   = '1;
    assign m_axi_wlast_o   = (state_q == ST_DATA) && last_beat;

    assign m_axi_bready_o  = (state_q == ST_RESP);

endmodule

// File: doc/dma_wr_master.md
Name: dma_wr_master

Overview:
AXI4 write-burst master feeding the double-buffered AXI write slave.
- Accepts a transfer command (base address, length in beats) and drains a valid/ready source stream.
- Issues the transfer as one or more INCR bursts on the AW/W/B channels.
- Pulses done when the final write response is accepted.
- Sits between the source stream (line fetch / pixel stream) and the buffer slave's AXI write port.

Parameters:
AXI_DW_g, 64, AXI data width in bits (power of 2, ≥ 8)
AXI_AW_g, 32, AXI address width in bits
MAX_BURST_g, 16, maximum beats per burst (1..256)
LEN_W_g, 16, width of the command length field

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when high with cmd_valid_i
cmd_addr_i  input  AXI_AW_g  byte base address, beat-aligned
cmd_len_i  input  LEN_W_g  total beats; 0 is legal
busy_o  output  1  transfer in progress
done_o  output  1  one-cycle pulse at transfer end
err_o  output  1  sticky error, cleared on next command accept
src_valid_i  input  1  source data valid
src_ready_o  output  1  source data consumed
src_data_i  input  AXI_DW_g  source data
m_axi_awvalid_o  output  1  write address valid
m_axi_awready_i  input  1  write address ready
m_axi_awaddr_o  output  AXI_AW_g  burst start address
m_axi_awlen_o  output  8  beats-1
m_axi_awsize_o  output  3  constant $clog2(AXI_DW_g/8)
m_axi_awburst_o  output  2  constant INCR (2'b01)
m_axi_awprot_o  output  3  constant 0
m_axi_awcache_o  output  4  constant 0
m_axi_wvalid_o  output  1  write data valid
m_axi_wready_i  input  1  write data ready
m_axi_wdata_o  output  AXI_DW_g  write data
m_axi_wstrb_o  output  AXI_DW_g/8  all ones
m_axi_wlast_o  output  1  last beat of burst
m_axi_bvalid_i  input  1  write response valid
m_axi_bready_o  output  1  write response ready
m_axi_bresp_i  input  2  write response code

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i; every flop clears immediately on rst_n_i low.
- Reset values:
  - State IDLE; cmd_ready_o=1 once reset is released.
  - awvalid, wvalid, wlast, bready, busy_o, done_o and err_o are all 0.
  - awaddr and awlen are 0.
- FSM states are IDLE, ADDR, DATA and RESP.
- IDLE:
  - cmd_ready_o=1.
  - On a cmd handshake, latch the address into cur_addr, latch the length into remaining, and clear err_o.
  - If len==0: stay in IDLE and pulse done_o on the next cycle. No AXI traffic is generated.
  - Otherwise go to ADDR. awvalid is asserted on the cycle after the handshake.
- ADDR:
  - burst_beats = min(remaining, MAX_BURST_g), computed and registered when entering ADDR.
  - awaddr = cur_addr; awlen = burst_beats-1.
  - awvalid stays high and all AW fields stay stable until awready. Then go to DATA with beat_cnt=0.
- DATA:
  - Pass-through: wvalid = src_valid_i, src_ready_o = wready_i, wdata = src_data_i.
  - src_ready_o is 0 in every other state.
  - wlast = (beat_cnt == burst_beats-1).
  - beat_cnt increments on each W handshake. The handshake carrying wlast moves the FSM to RESP.
- RESP:
  - bready=1.
  - On the B handshake: remaining -= burst_beats; cur_addr += burst_beats*(AXI_DW_g/8), wrapping modulo 2^AXI_AW_g.
  - If remaining==0: go to IDLE and pulse done_o in the same cycle as the transition register update, i.e. the cycle after the handshake. Otherwise go to ADDR.
- busy_o = (state != IDLE).
- No AW/W overlap: W is never driven before the AW handshake, and only one burst is outstanding.
- The caller guarantees bursts do not cross a 4 KB boundary. No splitting is performed for 4 KB boundaries.
- Commands presented while busy are held off (cmd_ready_o=0).
- Reset asserted mid-burst: outputs drop at once and no partial state survives. The downstream slave is reset by the same rst_n_i.

Optional Feature:
Macro DMA_WR_BRESP_CHK_EN.
- Defined: a B handshake with bresp != 2'b00 sets err_o.
  - The remaining bursts are abandoned and the FSM returns to IDLE.
  - done_o pulses as for normal completion.
- Undefined: bresp is ignored, err_o is tied to 0, and all bursts always complete.

Decomposition:
- Package dma_wr_pkg:
  - FSM state enum dma_wr_state_t.
  - Constants AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - Function for awsize from the data width.
- No sub-module. The burst-length computation and counters are a single always_ff/always_comb pair each in the one module.

Test Plan:
1. DW=64, MAX=16; cmd addr 0x1000, len 4, bresp OKAY:
   - One AW: awaddr=0x1000, awlen=3, awsize=3, awburst=1.
   - 4 W beats, wlast on beat 4.
   - done_o one pulse one cycle after the B handshake; err_o=0.
2. len 40, addr 0x0:
   - Three bursts: awaddr 0x0, 0x80, 0x100 with awlen 15, 15, 7.
   - Exactly 40 W beats; done_o once.
3. Random wready toggling and src_valid gaps on len 20:
   - W data order equals source order.
   - wvalid never high without src_valid_i.
   - AW fields stable while awvalid is high and awready is low.
4. len 0 → done_o pulses the cycle after the cmd handshake; awvalid stays 0 throughout.
5. rst_n_i low during beat 2 of 4 → all outputs 0 in that same cycle; after release, cmd_ready_o=1 and a new len-4 command completes normally.
6. With DMA_WR_BRESP_CHK_EN, len 48, SLVERR on the first B → err_o=1, done_o pulses, no second AW. Without the macro, the same stimulus completes 3 bursts and err_o stays 0.
